// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared size encodings, FSM states and helpers for mem_access_unit
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } mau_state_e;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 32'h0000_00ff;
      SZ_HALF: return 32'h0000_ffff;
      default: return 32'hffff_ffff;
    endcase
  endfunction

endpackage

// File: rtl/mau_load_ext.sv
// rtl/mau_load_ext.sv - sign/zero extension of right-justified load data
module mau_load_ext
  import mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [31:0] raw_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = raw_i;
    case (size_i)
      SZ_BYTE: data_o = {{24{signed_i & raw_i[7]}}, raw_i[7:0]};
      SZ_HALF: data_o = {{16{signed_i & raw_i[15]}}, raw_i[15:0]};
      default: data_o = raw_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store initiator with checks, fixed-latency RAM access and response handshake
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int MEM_BYTES = 256,
  parameter int LATENCY   = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_en,
  output logic        mem_rw,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  mau_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rw_q, rw_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [32:0] end_addr;
  logic        req_err;
  logic [31:0] ext_data;

  // End address is computed one bit wider so addresses near 2^32 cannot wrap into range.
  assign end_addr = {1'b0, req_addr} + 33'(size_bytes(req_size));
  assign req_err  = (req_size == SZ_RSVD)
                 || (req_size == SZ_HALF && req_addr[0] != 1'b0)
                 || (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
                 || (end_addr > 33'(MEM_BYTES));

  mau_load_ext u_load_ext (
    .size_i   (size_q),
    .signed_i (signed_q),
    .raw_i    (mem_rdata),
    .data_o   (ext_data)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rw_d     = rw_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          rw_d     = req_rw;
          size_d   = req_size;
          signed_d = req_signed;
          addr_d   = req_addr;
          wdata_d  = req_wdata & size_mask(req_size);
          rdata_d  = 32'h0;
          err_d    = req_err;
          cnt_d    = CNT_INIT;
          state_d  = req_err ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (!rw_q) rdata_d = ext_data;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      rw_q     <= 1'b0;
      size_q   <= SZ_BYTE;
      signed_q <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rw_q     <= rw_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Strobes decode straight from the state register so a reset drops them without a clock.
  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign mem_en    = (state_q == ST_ACCESS);
  assign mem_rw    = (state_q == ST_ACCESS) && rw_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_size  = size_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed and random checks of mem_access_unit at LATENCY 1 and 3
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_rw    [2];
  logic [1:0]  req_size  [2];
  logic        req_signed[2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic        mem_en    [2];
  logic        mem_rw    [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [1:0]  mem_size  [2];
  logic [31:0] mem_rdata [2];

  logic [7:0] ram     [2][256];
  logic [7:0] ref_mem [2][256];
  int lat [2] = '{1, 3};
  int checks = 0;
  int errors = 0;
  int rw_viol = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_BYTES(256), .LATENCY(1)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_rw(req_rw[0]),
    .req_size(req_size[0]), .req_signed(req_signed[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .mem_en(mem_en[0]),
    .mem_rw(mem_rw[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_size(mem_size[0]), .mem_rdata(mem_rdata[0]));

  mem_access_unit #(.MEM_BYTES(256), .LATENCY(3)) dut3 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_rw(req_rw[1]),
    .req_size(req_size[1]), .req_signed(req_signed[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .mem_en(mem_en[1]),
    .mem_rw(mem_rw[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_size(mem_size[1]), .mem_rdata(mem_rdata[1]));

  // Big-endian RAM: byte at the address is the most significant of the access.
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (mem_en[u] && mem_rw[u]) begin
        case (mem_size[u])
          2'b00: ram[u][mem_addr[u][7:0]] <= mem_wdata[u][7:0];
          2'b01: begin
            ram[u][mem_addr[u][7:0]]        <= mem_wdata[u][15:8];
            ram[u][mem_addr[u][7:0] + 8'd1] <= mem_wdata[u][7:0];
          end
          default: begin
            ram[u][mem_addr[u][7:0]]        <= mem_wdata[u][31:24];
            ram[u][mem_addr[u][7:0] + 8'd1] <= mem_wdata[u][23:16];
            ram[u][mem_addr[u][7:0] + 8'd2] <= mem_wdata[u][15:8];
            ram[u][mem_addr[u][7:0] + 8'd3] <= mem_wdata[u][7:0];
          end
        endcase
      end
    end
  end

  always @* begin
    for (int u = 0; u < 2; u++) begin
      case (mem_size[u])
        2'b00:   mem_rdata[u] = {24'h0, ram[u][mem_addr[u][7:0]]};
        2'b01:   mem_rdata[u] = {16'h0, ram[u][mem_addr[u][7:0]], ram[u][mem_addr[u][7:0] + 8'd1]};
        default: mem_rdata[u] = {ram[u][mem_addr[u][7:0]], ram[u][mem_addr[u][7:0] + 8'd1],
                                 ram[u][mem_addr[u][7:0] + 8'd2], ram[u][mem_addr[u][7:0] + 8'd3]};
      endcase
    end
  end

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++)
      if (mem_rw[u] && (!mem_en[u] || req_ready[u] || rsp_valid[u])) rw_viol++;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic model_err(input logic [1:0] size, input logic [31:0] addr);
    longint last;
    last = longint'(addr) + nbytes(size);
    return (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00) || (last > 256);
  endfunction

  function automatic logic [31:0] model_load(input int u, input logic [1:0] size, input logic sgn, input logic [31:0] addr);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < nbytes(size); i++) v = {v[23:0], ref_mem[u][addr[7:0] + 8'(i)]};
    if (sgn && size == 2'b00 && v[7])  v = v | 32'hffff_ff00;
    if (sgn && size == 2'b01 && v[15]) v = v | 32'hffff_0000;
    return v;
  endfunction

  task automatic model_store(input int u, input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wd);
    int n = nbytes(size);
    for (int i = 0; i < n; i++) ref_mem[u][addr[7:0] + 8'(i)] = wd[8*(n-1-i) +: 8];
  endtask

  task automatic check_reset(input int u, input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready[u]), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid[u]), 32'd0);
    chk({tag, "_rsp_err"},   32'(rsp_err[u]),   32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata[u],      32'd0);
    chk({tag, "_mem_en"},    32'(mem_en[u]),    32'd0);
    chk({tag, "_mem_rw"},    32'(mem_rw[u]),    32'd0);
    chk({tag, "_mem_addr"},  mem_addr[u],       32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata[u],      32'd0);
    chk({tag, "_mem_size"},  32'(mem_size[u]),  32'd0);
  endtask

  task automatic do_req(input int u, input logic rw, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic exp_err,
                        input logic [31:0] exp_rdata, input int hold, input string name);
    int c;
    int en_cnt = 0;
    int rw_cnt = 0;
    int bad_size = 0;
    @(negedge clk);
    chk({name, "_ready_in"}, 32'(req_ready[u]), 32'd1);
    req_valid[u] = 1'b1; req_rw[u] = rw; req_size[u] = size;
    req_signed[u] = sgn; req_addr[u] = addr; req_wdata[u] = wdata;
    @(posedge clk);
    #1 req_valid[u] = 1'b0;
    for (c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (rsp_valid[u]) break;
      if (mem_en[u]) en_cnt++;
      if (mem_rw[u]) rw_cnt++;
      if (mem_en[u] && mem_size[u] != size) bad_size++;
    end
    chk({name, "_latency"}, 32'(c), exp_err ? 32'd1 : 32'(1 + lat[u]));
    chk({name, "_err"}, 32'(rsp_err[u]), 32'(exp_err));
    chk({name, "_rdata"}, rsp_rdata[u], exp_rdata);
    chk({name, "_en_cycles"}, 32'(en_cnt), exp_err ? 32'd0 : 32'(lat[u]));
    chk({name, "_rw_cycles"}, 32'(rw_cnt), (exp_err || !rw) ? 32'd0 : 32'(lat[u]));
    chk({name, "_mem_size"}, 32'(bad_size), 32'd0);
    for (int h = 0; h < hold; h++) begin
      req_valid[u] = 1'b1;
      @(negedge clk);
      chk({name, "_hold_valid"}, 32'(rsp_valid[u]), 32'd1);
      chk({name, "_hold_rdata"}, rsp_rdata[u], exp_rdata);
      chk({name, "_hold_ready"}, 32'(req_ready[u]), 32'd0);
    end
    req_valid[u] = 1'b0;
    rsp_ready[u] = 1'b1;
    @(posedge clk);
    #1 rsp_ready[u] = 1'b0;
    @(negedge clk);
    chk({name, "_ready_after"}, 32'(req_ready[u]), 32'd1);
    chk({name, "_valid_after"}, 32'(rsp_valid[u]), 32'd0);
  endtask

  typedef struct {
    logic        rw;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rw, input logic [1:0] size, input logic sgn, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic err, input logic [31:0] rdata);
    vec_t v;
    v.rw = rw; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata; v.err = err; v.rdata = rdata;
    return v;
  endfunction

  initial begin
    logic        rw, sgn, e;
    logic [1:0]  size;
    logic [31:0] addr, wd, exp_rd;
    for (int u = 0; u < 2; u++) begin
      req_valid[u] = 1'b0; req_rw[u] = 1'b0; req_size[u] = 2'b00; req_signed[u] = 1'b0;
      req_addr[u] = 32'h0; req_wdata[u] = 32'h0; rsp_ready[u] = 1'b0;
      for (int i = 0; i < 256; i++) begin ram[u][i] = 8'h00; ref_mem[u][i] = 8'h00; end
    end

    vecs.push_back(mk(1, 2'b10, 0, 32'h10,  32'hDEADBEEF, 0, 32'h0));
    vecs.push_back(mk(0, 2'b00, 1, 32'h10,  32'h0,        0, 32'hFFFFFFDE));
    vecs.push_back(mk(0, 2'b01, 0, 32'h12,  32'h0,        0, 32'h0000BEEF));
    vecs.push_back(mk(0, 2'b10, 0, 32'h11,  32'h0,        1, 32'h0));
    vecs.push_back(mk(0, 2'b10, 0, 32'hFE,  32'h0,        1, 32'h0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h11,  32'h0,        0, 32'h000000AD));
    vecs.push_back(mk(0, 2'b01, 1, 32'h10,  32'h0,        0, 32'hFFFFDEAD));
    vecs.push_back(mk(1, 2'b00, 0, 32'h20,  32'h12345677, 0, 32'h0));
    vecs.push_back(mk(0, 2'b00, 1, 32'h20,  32'h0,        0, 32'h00000077));
    vecs.push_back(mk(1, 2'b01, 0, 32'h22,  32'hFFFF8001, 0, 32'h0));
    vecs.push_back(mk(0, 2'b01, 1, 32'h22,  32'h0,        0, 32'hFFFF8001));
    vecs.push_back(mk(0, 2'b10, 0, 32'h20,  32'h0,        0, 32'h77008001));
    vecs.push_back(mk(0, 2'b11, 0, 32'h00,  32'h0,        1, 32'h0));
    vecs.push_back(mk(0, 2'b00, 0, 32'hFF,  32'h0,        0, 32'h0));
    vecs.push_back(mk(0, 2'b10, 0, 32'hFC,  32'h0,        0, 32'h0));
    vecs.push_back(mk(1, 2'b01, 0, 32'hFF,  32'h1234,     1, 32'h0));
    vecs.push_back(mk(1, 2'b10, 0, 32'h100, 32'h1234,     1, 32'h0));

    #2;
    check_reset(0, "rst0_u0");
    check_reset(1, "rst0_u1");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      do_req(0, vecs[i].rw, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
             vecs[i].err, vecs[i].rdata, 0, $sformatf("vec%0d", i));
      if (i == 0) chk("ram_10_13", {ram[0][8'h10], ram[0][8'h11], ram[0][8'h12], ram[0][8'h13]}, 32'hDEADBEEF);
    end
    model_store(0, 2'b10, 32'h10, 32'hDEADBEEF);
    model_store(0, 2'b00, 32'h20, 32'h77);
    model_store(0, 2'b01, 32'h22, 32'h8001);

    do_req(1, 1, 2'b10, 0, 32'h30, 32'hA1B2C3D4, 0, 32'h0, 0, "l3_store");
    model_store(1, 2'b10, 32'h30, 32'hA1B2C3D4);
    do_req(1, 0, 2'b01, 1, 32'h32, 32'h0, 0, 32'hFFFFC3D4, 4, "l3_hold");

    @(negedge clk);
    req_valid[1] = 1'b1; req_rw[1] = 1'b1; req_size[1] = 2'b10; req_signed[1] = 1'b0;
    req_addr[1] = 32'h40; req_wdata[1] = 32'hCAFEF00D;
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(negedge clk);
    chk("abort_rw_first", 32'(mem_rw[1]), 32'd1);
    @(negedge clk);
    chk("abort_rw_second", 32'(mem_rw[1]), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check_reset(1, "abort_u1");
    check_reset(0, "abort_u0");
    #1 reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("abort_no_rsp", 32'(rsp_valid[1]), 32'd0);
      chk("abort_no_en", 32'(mem_en[1]), 32'd0);
    end
    model_store(1, 2'b10, 32'h40, 32'hCAFEF00D);
    do_req(1, 0, 2'b10, 0, 32'h40, 32'h0, 0, 32'hCAFEF00D, 0, "after_abort");

    for (int k = 0; k < 40; k++) begin
      int u = k % 2;
      rw   = 1'($urandom_range(0, 1));
      sgn  = 1'($urandom_range(0, 1));
      size = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      addr = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) addr = addr & ~(32'(nbytes(size)) - 32'd1);
      if (k % 13 == 5) addr = 32'h12C;
      wd   = $urandom;
      e    = model_err(size, addr);
      exp_rd = (!e && !rw) ? model_load(u, size, sgn, addr) : 32'h0;
      do_req(u, rw, size, sgn, addr, wd, e, exp_rd, int'($urandom_range(0, 2)), $sformatf("rnd%0d", k));
      if (!e && rw) model_store(u, size, addr, wd);
    end

    chk("rw_window", 32'(rw_viol), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Initiator side of the data-memory interface: sits in the MEM stage between the pipeline's load/store request and the byte-addressed data RAM (big-endian, 256 B, byte/half/word sizes). It accepts one request at a time over a valid/ready handshake and checks size, alignment and range. It then drives the RAM port for a fixed number of access cycles, sign/zero-extends load data, and returns a response over a second valid/ready handshake.

## Interface
- `MEM_BYTES`, 256: RAM size in bytes; legal addresses are 0..MEM_BYTES-1.
- `LATENCY`, 1: access cycles the RAM port is driven before read data is sampled (1..15).
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request.
- `req_rw` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 reserved.
- `req_signed` in 1: sign-extend load data.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_rdata` out 32: extended load data; 0 for stores and errors.
- `rsp_err` out 1: request rejected.
- `mem_en` out 1: RAM enable.
- `mem_rw` out 1: RAM write strobe.
- `mem_addr` out 32: RAM address.
- `mem_wdata` out 32: RAM write data.
- `mem_size` out 2: RAM access size.
- `mem_rdata` in 32: RAM read data, right-justified.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch rw, size, signed, addr and wdata.
- Store data is latched with bits above the access size forced to 0.
- Error check at accept, giving `err` = size==11, or half with addr[0]≠0, or word with addr[1:0]≠0, or addr+bytes > MEM_BYTES.
- On error, go to RESP with `rsp_err`=1 and `rsp_rdata`=0; the RAM port is never driven. Otherwise go to ACCESS with the counter loaded to LATENCY-1.
- ACCESS: `mem_en`=1, and `mem_rw`=req_rw. The counter decrements each cycle.
- ACCESS, last cycle (counter 0): for loads, register `mem_rdata` through the extender, then go to RESP.
- Extension: byte uses bits [7:0], half uses [15:0], word passes through. The upper bits are zero-filled, or replicated from bit 7/15 when signed.
- RESP: `rsp_valid`=1 and outputs are held stable. On `rsp_ready`, go to IDLE.
- The RAM has no internal gating, so `mem_rw` may be 1 only during ACCESS of a store; it is 0 in every other state.
- `mem_addr`, `mem_size` and `mem_wdata` are registered at accept and held unchanged until the next accept, so they never change while `mem_rw`=1.
- Byte order matches the RAM: the byte at addr is the most significant.

## Timing
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0, `mem_en`=0, `mem_rw`=0, `mem_addr`=0, `mem_wdata`=0, `mem_size`=0.
- Reset mid-ACCESS aborts immediately: `mem_rw` drops asynchronously, and no response is produced.
- Request accepted at edge N:
  - ACCESS occupies cycles N+1 .. N+LATENCY.
  - `rsp_valid` rises at N+1+LATENCY.
  - Error responses rise at N+1.
- Response taken at edge M: `req_ready`=1 at M+1.
- Peak throughput is one request per LATENCY+2 cycles.
- `req_ready`=0 in ACCESS and RESP; `req_valid` is ignored there.
- `rsp_valid` never drops without `rsp_ready`.

## Structure
- Package `mem_pkg`: size encodings SZ_BYTE, SZ_HALF, SZ_WORD; the FSM state enum; the byte-count function (size → 1/2/4).
- One sub-module is natural: `mau_load_ext`, combinational (size, signed, raw data → extended data).
- The FSM, counter and checks stay in `mem_access_unit`.

## Test plan
- Word store 0xDEADBEEF at 0x10, LATENCY=1:
  - `mem_rw`=1 for exactly 1 cycle, `mem_size`=10.
  - Response with err=0 at N+2, and RAM bytes 0x10..0x13 = DE AD BE EF.
- Signed byte load at 0x10 → `rsp_rdata`=0xFFFFFFDE. Unsigned half load at 0x12 → 0x0000BEEF.
- Word load at 0x11 → err=1, rdata=0 at N+1, `mem_en` never asserted. Word load at 0xFE → same error.
- LATENCY=3, `rsp_ready` held low 4 cycles:
  - `rsp_valid` and `rsp_rdata` stay stable and `req_ready`=0 throughout.
  - After the handshake, `req_ready`=1 the next cycle.
- `reset_n` pulsed low in the second ACCESS cycle of a store (LATENCY=3):
  - All outputs return to reset values without waiting for a clock, and no response is produced.
  - The next request completes normally.
- Back-to-back random loads and stores against a reference byte-array model: every response matches, and `mem_rw` is never 1 outside store ACCESS cycles.
